// File: rtl/cmplx_mult_driver_if.sv
// rtl/cmplx_mult_driver_if.sv - operand, multiplier and result handshake bundle for cmplx_mult_driver
interface cmplx_mult_driver_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int RES_WIDTH = 2 * DATA_WIDTH + 1;

  logic                        in_val;
  logic                        in_ready;
  logic signed [DATA_WIDTH-1:0] in_a_re;
  logic signed [DATA_WIDTH-1:0] in_a_im;
  logic signed [DATA_WIDTH-1:0] in_b_re;
  logic signed [DATA_WIDTH-1:0] in_b_im;

  logic                        op_val;
  logic                        op_ready;
  logic signed [DATA_WIDTH-1:0] op_a_re;
  logic signed [DATA_WIDTH-1:0] op_a_im;
  logic signed [DATA_WIDTH-1:0] op_b_re;
  logic signed [DATA_WIDTH-1:0] op_b_im;

  logic                        res_val;
  logic                        res_ready;
  logic signed [RES_WIDTH-1:0] res_re;
  logic signed [RES_WIDTH-1:0] res_im;

  logic                        out_val;
  logic                        out_ready;
  logic signed [RES_WIDTH-1:0] out_re;
  logic signed [RES_WIDTH-1:0] out_im;

  // master is the driver's view; slave is the surrounding upstream/multiplier/sink view
  modport master (
    input  in_val, in_a_re, in_a_im, in_b_re, in_b_im,
    output in_ready,
    output op_val, op_a_re, op_a_im, op_b_re, op_b_im,
    input  op_ready,
    input  res_val, res_re, res_im,
    output res_ready,
    output out_val, out_re, out_im,
    input  out_ready
  );

  modport slave (
    output in_val, in_a_re, in_a_im, in_b_re, in_b_im,
    input  in_ready,
    input  op_val, op_a_re, op_a_im, op_b_re, op_b_im,
    output op_ready,
    output res_val, res_re, res_im,
    input  res_ready,
    input  out_val, out_re, out_im,
    output out_ready
  );
endinterface

// File: rtl/cmplx_mult_driver.sv
// rtl/cmplx_mult_driver.sv - operand FIFO, issuer and result collector for the complex multiplier
// Optional result watchdog is built only when CMPLX_DRV_TIMEOUT_EN is defined.
module cmplx_mult_driver #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  cmplx_mult_driver_if.master    bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_timeout
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2 * DATA_WIDTH + 1;
  localparam int EW = 4 * DATA_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT_RES} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          res_take;
  logic          out_take;
  logic          tmo_hit;

  assign bus.in_ready  = (fifo_count < FULL);
  assign push          = bus.in_val && bus.in_ready;
  assign pop           = (state == D_IDLE) && (fifo_count != '0);
  // Result is only accepted when the output register is free or draining this cycle.
  assign bus.res_ready = (state == D_WAIT_RES) && (!bus.out_val || bus.out_ready);
  assign res_take      = bus.res_val && bus.res_ready;
  assign out_take      = bus.out_val && bus.out_ready;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_a_re, bus.in_a_im, bus.in_b_re, bus.in_b_im};
    end
  end

`ifdef CMPLX_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == D_WAIT_RES) && !bus.res_val &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else if (sw_rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == D_ISSUE && bus.op_ready) begin
        tmo_cnt <= '0;
      end else if (state == D_WAIT_RES && !bus.res_val) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (tmo_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= D_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      bus.op_val  <= 1'b0;
      bus.op_a_re <= '0;
      bus.op_a_im <= '0;
      bus.op_b_re <= '0;
      bus.op_b_im <= '0;
      bus.out_val <= 1'b0;
      bus.out_re  <= '0;
      bus.out_im  <= '0;
    end else if (sw_rst) begin
      // Operand and result data registers deliberately keep their contents.
      state       <= D_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      bus.op_val  <= 1'b0;
      bus.out_val <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (out_take) begin
        bus.out_val <= 1'b0;
      end

      case (state)
        D_IDLE: begin
          if (pop) begin
            bus.op_a_re <= head[EW-1 -: DATA_WIDTH];
            bus.op_a_im <= head[EW-DATA_WIDTH-1 -: DATA_WIDTH];
            bus.op_b_re <= head[2*DATA_WIDTH-1 -: DATA_WIDTH];
            bus.op_b_im <= head[DATA_WIDTH-1:0];
            rd_ptr      <= rd_ptr + PW'(1);
            bus.op_val  <= 1'b1;
            state       <= D_ISSUE;
          end
        end
        D_ISSUE: begin
          if (bus.op_ready) begin
            bus.op_val <= 1'b0;
            state      <= D_WAIT_RES;
          end
        end
        D_WAIT_RES: begin
          // A same-cycle capture overrides the drain clear above.
          if (res_take) begin
            bus.out_re  <= bus.res_re[RW-1:0];
            bus.out_im  <= bus.res_im[RW-1:0];
            bus.out_val <= 1'b1;
            state       <= D_IDLE;
          end else if (tmo_hit) begin
            state <= D_IDLE;
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end
endmodule
